// File: rtl/nios_sys_pio_gpio_ctrl.sv
// nios_sys_pio_gpio_ctrl
// Avalon-MM GPIO controller. It provides per-bit direction, synchronised inputs,
// edge capture with write-1-to-clear, a maskable level interrupt, and atomic
// set/clear of output bits.
//
// Ports
//   clk         system clock
//   reset_n     synchronous active-low reset
//   address     register word address (3 bits)
//   chipselect  slave select
//   read_n      active-low read strobe
//   write_n     active-low write strobe
//   writedata   32-bit write data
//   readdata    32-bit read data, registered, valid the cycle after the read strobe
//   in_port     asynchronous GPIO inputs (WIDTH)
//   out_port    GPIO output values (WIDTH)
//   out_oe      per-bit output enable, 1 = drive out_port (WIDTH)
//   irq         level interrupt
//
// Register map (bits at or above WIDTH read 0 and ignore writes)
//   0 DATA     R: synchronised inputs      W: out_port
//   1 DIR      R/W: out_oe
//   2 IRQMASK  R/W: interrupt mask
//   3 EDGECAP  R: captured edges           W: clear bits written as 1
//   4 OUTSET   W: out_port |= wd           R: 0
//   5 OUTCLR   W: out_port &= ~wd          R: 0
//   6,7        reserved: R 0, W ignored
//
// Bus handshake: this is an Avalon-MM slave with no waitrequest. A transfer
// happens on every cycle where chipselect is high and a strobe is low, and it
// completes in that same cycle. Write effects become visible on the next cycle.
// Read data is registered on the strobe edge, so it is valid on the next cycle.
// readdata holds its value until the next read. When a read and a write hit
// the same register in one cycle, the read returns the value from before the
// write.
module nios_sys_pio_gpio_ctrl #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               EDGE_TYPE   = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             read_n,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] out_oe,
  output logic             irq
);

  localparam logic [2:0] A_DATA    = 3'd0;
  localparam logic [2:0] A_DIR     = 3'd1;
  localparam logic [2:0] A_IRQMASK = 3'd2;
  localparam logic [2:0] A_EDGECAP = 3'd3;
  localparam logic [2:0] A_OUTSET  = 3'd4;
  localparam logic [2:0] A_OUTCLR  = 3'd5;

  logic             wr;
  logic             rd;
  logic [WIDTH-1:0] wd;

  logic [WIDTH-1:0] in_meta;
  logic [WIDTH-1:0] in_s;
  logic [WIDTH-1:0] in_s_d;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecap;

  logic [WIDTH-1:0] out_next;
  logic [WIDTH-1:0] oe_next;
  logic [WIDTH-1:0] mask_next;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] cap_clr;
  logic [WIDTH-1:0] edgecap_next;
  logic [31:0]      rd_mux;

  // The upper writedata bits are unused when WIDTH is below 32.
  logic unused_wd;
  assign unused_wd = ^writedata;

  assign wr = chipselect & ~write_n;
  assign rd = chipselect & ~read_n;
  assign wd = writedata[WIDTH-1:0];

  always_comb begin
    out_next  = out_port;
    oe_next   = out_oe;
    mask_next = irqmask;
    cap_clr   = '0;
    if (wr) begin
      case (address)
        A_DATA:    out_next  = wd;
        A_DIR:     oe_next   = wd;
        A_IRQMASK: mask_next = wd;
        A_EDGECAP: cap_clr   = wd;
        A_OUTSET:  out_next  = out_port | wd;
        A_OUTCLR:  out_next  = out_port & ~wd;
        default:   ;
      endcase
    end
  end

  // Edges are taken from the synchronised value against its one-cycle delay.
  always_comb begin
    edge_det = '0;
    case (EDGE_TYPE)
      0:       edge_det = in_s & ~in_s_d;
      1:       edge_det = ~in_s & in_s_d;
      default: edge_det = in_s ^ in_s_d;
    endcase
  end

  // A new edge wins over a simultaneous write-1-to-clear on the same bit.
  assign edgecap_next = (edgecap & ~cap_clr) | edge_det;

  // Reads use the current register values, which gives pre-write data when a
  // read and a write happen in the same cycle.
  always_comb begin
    rd_mux = '0;
    case (address)
      A_DATA:    rd_mux[WIDTH-1:0] = in_s;
      A_DIR:     rd_mux[WIDTH-1:0] = out_oe;
      A_IRQMASK: rd_mux[WIDTH-1:0] = irqmask;
      A_EDGECAP: rd_mux[WIDTH-1:0] = edgecap;
      default:   rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      in_meta  <= '0;
      in_s     <= '0;
      in_s_d   <= '0;
      out_port <= RESET_VALUE;
      out_oe   <= '0;
      irqmask  <= '0;
      edgecap  <= '0;
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      in_meta  <= in_port;
      in_s     <= in_meta;
      in_s_d   <= in_s;
      out_port <= out_next;
      out_oe   <= oe_next;
      irqmask  <= mask_next;
      edgecap  <= edgecap_next;
      if (rd) readdata <= rd_mux;
      // Computing irq from the next-state values keeps it aligned with the
      // visible edgecap and irqmask registers. It rises in the same cycle a
      // capture appears, and it falls in the cycle after the clearing write.
      irq      <= |(edgecap_next & mask_next);
    end
  end

endmodule
